// File: rtl/timeline_driver.sv
// Single-transaction timing driver: accepts four operands, replays them to a fixed-latency
// datapath on a per-offset schedule, and captures the datapath results for a ready/valid consumer.
module timeline_driver #(
  parameter int OUT0_LAT = 1,
  parameter int OUT1_LAT = 3,
  parameter int II       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_l0,
  input  logic [31:0] in_r0,
  input  logic [31:0] in_l1,
  input  logic [31:0] in_r1,
  output logic        go,
  output logic [31:0] l0,
  output logic [31:0] r0,
  output logic [31:0] l1,
  output logic [31:0] r1,
  input  logic [31:0] out0,
  input  logic [31:0] out1,
  input  logic        done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_out0,
  output logic [31:0] res_out1,
  output logic        res_err
);

  // RUN lasts through offset K_END so consecutive gos honour both the operand schedule and II.
  localparam int K_A   = (OUT1_LAT > 3) ? OUT1_LAT : 3;
  localparam int K_END = (K_A > (II - 1)) ? K_A : (II - 1);

  localparam logic [4:0] K_O0   = 5'(OUT0_LAT);
  localparam logic [4:0] K_O1   = 5'(OUT1_LAT);
  localparam logic [4:0] K_LAST = 5'(K_END);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t      r_state;
  logic [4:0]  r_k;
  logic [31:0] r_l0, r_r0, r_l1, r_r1;
  logic [31:0] r_res_out0, r_res_out1;
  logic        r_res_err;
  logic        w_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_l0       <= '0;
      r_r0       <= '0;
      r_l1       <= '0;
      r_r1       <= '0;
      r_res_out0 <= '0;
      r_res_out1 <= '0;
      r_res_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_l0    <= in_l0;
            r_r0    <= in_r0;
            r_l1    <= in_l1;
            r_r1    <= in_r1;
            r_k     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_k == K_O0) r_res_out0 <= out0;
          if (r_k == K_O1) begin
            r_res_out1 <= out1;
            r_res_err  <= ~done;
          end
          if (r_k == K_LAST) r_state <= RESP;
          else               r_k     <= r_k + 5'd1;
        end
        RESP: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_run     = (r_state == RUN);
    in_ready  = (r_state == IDLE) && !reset;
    go        = w_run && (r_k == 5'd0);
    l0        = (w_run && r_k <= 5'd1) ? r_l0 : '0;
    r0        = (w_run && r_k == 5'd0) ? r_r0 : '0;
    l1        = (w_run && (r_k == 5'd2 || r_k == 5'd3)) ? r_l1 : '0;
    r1        = (w_run && r_k == 5'd2) ? r_r1 : '0;
    res_valid = (r_state == RESP);
    res_out0  = r_res_out0;
    res_out1  = r_res_out1;
    res_err   = r_res_err;
  end

endmodule

// File: tb/tb_timeline_driver.sv
// Bench for timeline_driver: a default instance and an OUT0_LAT=0/OUT1_LAT=7/II=10 instance,
// each driven by a fixed-latency datapath model, with results checked through a scoreboard.
module tb_timeline_driver;

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] l0, r0, l1, r1, o0, o1;
    logic        dn;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        d_in_valid, d_res_ready;
  logic [31:0] d_l0, d_r0, d_l1, d_r1;
  logic [31:0] m_out0, m_out1;
  logic        m_done;
  logic [31:0] r_noise;

  logic        a_in_valid, a_in_ready, a_go, a_out_done, a_res_valid, a_res_ready, a_res_err;
  logic [31:0] a_l0, a_r0, a_l1, a_r1, a_out0, a_out1, a_res_out0, a_res_out1;
  logic        b_in_valid, b_in_ready, b_go, b_out_done, b_res_valid, b_res_ready, b_res_err;
  logic [31:0] b_l0, b_r0, b_l1, b_r1, b_out0, b_out1, b_res_out0, b_res_out1;
  logic [5:0]  a_offr, b_offr, a_off, b_off;

  logic        c_in_ready, c_go, c_res_valid, c_res_err;
  logic [31:0] c_l0, c_r0, c_l1, c_r1, c_res_out0, c_res_out1;

  res_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  timeline_driver dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_l0(d_l0), .in_r0(d_r0), .in_l1(d_l1), .in_r1(d_r1),
    .go(a_go), .l0(a_l0), .r0(a_r0), .l1(a_l1), .r1(a_r1),
    .out0(a_out0), .out1(a_out1), .done(a_out_done),
    .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_out0(a_res_out0), .res_out1(a_res_out1), .res_err(a_res_err)
  );

  timeline_driver #(.OUT0_LAT(0), .OUT1_LAT(7), .II(10)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_l0(d_l0), .in_r0(d_r0), .in_l1(d_l1), .in_r1(d_r1),
    .go(b_go), .l0(b_l0), .r0(b_r0), .l1(b_l1), .r1(b_r1),
    .out0(b_out0), .out1(b_out1), .done(b_out_done),
    .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_out0(b_res_out0), .res_out1(b_res_out1), .res_err(b_res_err)
  );

  // Datapath model: offset counted from go; results only valid at their latency, junk elsewhere.
  always @(posedge clk) begin
    r_noise <= $urandom;
    if (reset)               a_offr <= 6'd63;
    else if (a_go)           a_offr <= 6'd1;
    else if (a_offr != 6'd63) a_offr <= a_offr + 6'd1;
    if (reset)               b_offr <= 6'd63;
    else if (b_go)           b_offr <= 6'd1;
    else if (b_offr != 6'd63) b_offr <= b_offr + 6'd1;
  end

  always_comb begin
    a_off      = a_go ? 6'd0 : a_offr;
    b_off      = b_go ? 6'd0 : b_offr;
    a_out0     = (a_off == 6'd1) ? m_out0 : r_noise;
    a_out1     = (a_off == 6'd3) ? m_out1 : ~r_noise;
    a_out_done = (a_off == 6'd3) ? m_done : ~m_done;
    b_out0     = (b_off == 6'd0) ? m_out0 : r_noise;
    b_out1     = (b_off == 6'd7) ? m_out1 : ~r_noise;
    b_out_done = (b_off == 6'd7) ? m_done : ~m_done;
    a_in_valid  = !sel && d_in_valid;
    b_in_valid  = sel && d_in_valid;
    a_res_ready = !sel && d_res_ready;
    b_res_ready = sel && d_res_ready;
    c_in_ready  = sel ? b_in_ready  : a_in_ready;
    c_go        = sel ? b_go        : a_go;
    c_l0        = sel ? b_l0        : a_l0;
    c_r0        = sel ? b_r0        : a_r0;
    c_l1        = sel ? b_l1        : a_l1;
    c_r1        = sel ? b_r1        : a_r1;
    c_res_valid = sel ? b_res_valid : a_res_valid;
    c_res_out0  = sel ? b_res_out0  : a_res_out0;
    c_res_out1  = sel ? b_res_out1  : a_res_out1;
    c_res_err   = sel ? b_res_err   : a_res_err;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_out0"}, c_res_out0, e.o0);
    chk({tag, "_out1"}, c_res_out1, e.o1);
    chk({tag, "_err"}, {31'd0, c_res_err}, {31'd0, e.err});
  endtask

  task automatic offer(input txn_t t);
    d_l0 = t.l0; d_r0 = t.r0; d_l1 = t.l1; d_r1 = t.r1;
    m_out0 = t.o0; m_out1 = t.o1; m_done = t.dn;
    d_in_valid = 1'b1;
  endtask

  task automatic scramble();
    d_l0 = $urandom; d_r0 = $urandom; d_l1 = $urandom; d_r1 = $urandom;
  endtask

  // One transaction on the default instance with the full operand schedule checked.
  task automatic directed(input txn_t t, input int hold);
    res_t e;
    offer(t);
    chk("idle_in_ready", {31'd0, c_in_ready}, 32'd1);
    e.o0 = t.o0; e.o1 = t.o1; e.err = !t.dn;
    sb.push_back(e);
    step();
    d_in_valid = 1'b0;
    scramble();
    for (int k = 0; k <= 3; k++) begin
      chk($sformatf("go_k%0d", k), {31'd0, c_go}, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("l0_k%0d", k), c_l0, (k <= 1) ? t.l0 : 32'd0);
      chk($sformatf("r0_k%0d", k), c_r0, (k == 0) ? t.r0 : 32'd0);
      chk($sformatf("l1_k%0d", k), c_l1, (k >= 2) ? t.l1 : 32'd0);
      chk($sformatf("r1_k%0d", k), c_r1, (k == 2) ? t.r1 : 32'd0);
      chk($sformatf("rv_k%0d", k), {31'd0, c_res_valid}, 32'd0);
      step();
    end
    d_res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_res_valid", {31'd0, c_res_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, c_in_ready}, 32'd0);
      chk_res("hold", sb[0]);
      step();
    end
    d_res_ready = 1'b1;
    chk("resp_res_valid", {31'd0, c_res_valid}, 32'd1);
    chk_res("resp", sb.pop_front());
    step();
    d_res_ready = 1'b0;
    chk("post_res_valid", {31'd0, c_res_valid}, 32'd0);
    chk("post_in_ready", {31'd0, c_in_ready}, 32'd1);
  endtask

  // Back-to-back offers with res_ready tied high; checks go spacing, operands and results.
  task automatic b2b(input txn_t t0, input txn_t t1, input int mingap);
    txn_t tx[2];
    int   idx = 0, gos = 0, nres = 0, last_go = 0;
    bit   acc;
    res_t e;
    tx[0] = t0; tx[1] = t1;
    d_res_ready = 1'b1;
    offer(tx[0]);
    for (int cyc = 0; cyc < 200 && nres < 2; cyc++) begin
      if (c_go) begin
        if (gos > 0) chk("b2b_go_gap", {31'd0, (cyc - last_go) >= mingap}, 32'd1);
        if (gos < 2) begin
          chk("b2b_go_l0", c_l0, tx[gos].l0);
          chk("b2b_go_r0", c_r0, tx[gos].r0);
        end
        last_go = cyc;
        gos++;
      end
      if (c_res_valid) begin
        chk("b2b_sb_nonempty", sb.size(), (sb.size() != 0) ? sb.size() : 32'd1);
        if (sb.size() != 0) chk_res("b2b", sb.pop_front());
        nres++;
      end
      acc = c_in_ready && d_in_valid;
      if (acc) begin
        e.o0 = tx[idx].o0; e.o1 = tx[idx].o1; e.err = !tx[idx].dn;
        sb.push_back(e);
        m_out0 = tx[idx].o0; m_out1 = tx[idx].o1; m_done = tx[idx].dn;
      end
      step();
      if (acc) begin
        idx++;
        if (idx < 2) begin
          d_l0 = tx[idx].l0; d_r0 = tx[idx].r0; d_l1 = tx[idx].l1; d_r1 = tx[idx].r1;
        end else begin
          d_in_valid = 1'b0;
          scramble();
        end
      end
    end
    chk("b2b_results", nres, 32'd2);
    chk("b2b_gos", gos, 32'd2);
    d_res_ready = 1'b0;
    step();
  endtask

  initial begin
    txn_t t;
    sel = 1'b0; reset = 1'b1;
    d_in_valid = 1'b0; d_res_ready = 1'b0;
    d_l0 = '0; d_r0 = '0; d_l1 = '0; d_r1 = '0;
    m_out0 = '0; m_out1 = '0; m_done = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'd0, c_in_ready}, 32'd0);
    chk("rst_go", {31'd0, c_go}, 32'd0);
    chk("rst_l0", c_l0 | c_r0 | c_l1 | c_r1, 32'd0);
    chk("rst_res_valid", {31'd0, c_res_valid}, 32'd0);
    chk_res("rst", '{32'd0, 32'd0, 1'b0});
    reset = 1'b0;
    step();
    chk("rst_exit_in_ready", {31'd0, c_in_ready}, 32'd1);

    directed('{32'd10, 32'd20, 32'd30, 32'd40, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1}, 0);
    directed('{32'd10, 32'd20, 32'd30, 32'd40, 32'h0BAD_0001, 32'h0BAD_0002, 1'b0}, 0);
    directed('{32'hA1, 32'hB2, 32'hC3, 32'hD4, 32'h5555_AAAA, 32'hAAAA_5555, 1'b1}, 5);

    // Abort at k=2: nothing may come out afterwards.
    t = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h77, 32'h88, 1'b1};
    offer(t);
    step();
    d_in_valid = 1'b0;
    step();
    step();
    chk("abort_l1_k2", c_l1, 32'h33);
    reset = 1'b1;
    step();
    chk("abort_l1", c_l1, 32'd0);
    chk("abort_r1", c_r1, 32'd0);
    chk("abort_go", {31'd0, c_go}, 32'd0);
    chk("abort_in_ready_rst", {31'd0, c_in_ready}, 32'd0);
    reset = 1'b0;
    d_res_ready = 1'b1;
    step();
    chk("abort_in_ready", {31'd0, c_in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_res", {31'd0, c_res_valid}, 32'd0);
      step();
    end
    d_res_ready = 1'b0;

    b2b('{32'd1, 32'd2, 32'd3, 32'd4, 32'd100, 32'd200, 1'b1},
        '{32'd5, 32'd6, 32'd7, 32'd8, 32'd300, 32'd400, 1'b0}, 6);
    sel = 1'b1;
    step();
    b2b('{32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hCAFE, 32'hBEEF, 1'b1},
        '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hFACE, 32'hD00D, 1'b0}, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
